// File: rtl/sseg_scan_mux.sv
// -----------------------------------------------------------------------------
// sseg_scan_mux
//
// Time-multiplexes a 4-digit hex frame onto a 4-anode common-anode
// seven-segment display. A one-deep pending buffer with a valid/ready
// handshake keeps the display tear-free. A newly accepted frame becomes the
// active frame only at a frame boundary, which is the edge on which the
// refresh counter wraps after digit 3 and before digit 0. frame_start_o lets
// the upstream banner step its rotation once per displayed frame.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   hex_i[15:0]    frame digits; [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   dp_i[3:0]      decimal point per digit, 1 = lit
//   blank_i[3:0]   per-digit blank, 1 = digit dark
//   frame_valid_i  upstream frame presented
//   frame_ready_o  pending buffer empty; a frame is accepted on valid & ready
//   frame_start_o  one-clock pulse on the first output cycle of digit 0
//   an_o[3:0]      anodes, active-low, an_o[k] drives digit k
//   sseg_o[6:0]    segments {g,f,e,d,c,b,a}, active-low
//   dp_o           decimal point, active-low
//
// Parameter N is the refresh counter width (min 3). Each digit is lit for
// 2^(N-2) clocks and a full frame lasts 2^N clocks.
// -----------------------------------------------------------------------------
module sseg_scan_mux #(
    parameter int N = 18
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] hex_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blank_i,
    input  logic        frame_valid_i,
    output logic        frame_ready_o,
    output logic        frame_start_o,
    output logic [3:0]  an_o,
    output logic [6:0]  sseg_o,
    output logic        dp_o
);

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } frame_t;

    localparam frame_t BLANK_FRAME = '{hex: 16'h0000, dp: 4'h0, blank: 4'hF};

    logic [N-1:0] cnt;
    frame_t       active_q;
    frame_t       pending_q;
    logic         pending_valid_q;

    logic [1:0]   sel;
    logic         boundary;
    logic         accept;
    logic [3:0]   digit;
    logic [6:0]   seg_dec;
    logic [3:0]   an_next;
    logic [6:0]   sseg_next;
    logic         dp_next;

    // The two MSBs of the refresh counter walk the digits 0,1,2,3.
    assign sel      = cnt[N-1:N-2];
    assign boundary = &cnt;
    assign digit    = active_q.hex[{sel, 2'b00} +: 4];

    assign frame_ready_o = !pending_valid_q;
    assign accept        = frame_valid_i && !pending_valid_q;

    // Hex to active-low {g,f,e,d,c,b,a}.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the block leaves it unassigned (no latch).
        seg_dec = 7'b1111111;
        case (digit)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
            default: seg_dec = 7'b1111111;
        endcase
    end

    // Next output word. A blanked digit keeps all anodes off and
    // also darkens the segment and decimal-point lines.
    always_comb begin
        an_next   = 4'b1111;
        sseg_next = 7'b1111111;
        dp_next   = 1'b1;
        if (!active_q.blank[sel]) begin
            an_next[sel] = 1'b0;
            sseg_next    = seg_dec;
            dp_next      = ~active_q.dp[sel];
        end
    end

    // Refresh counter, handshake, frame promotion and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt             <= '0;
            active_q        <= BLANK_FRAME;
            pending_valid_q <= 1'b0;
            an_o            <= 4'b1111;
            sseg_o          <= 7'b1111111;
            dp_o            <= 1'b1;
            frame_start_o   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // right-hand side here sees the pre-edge value of the registers.
            cnt <= cnt + 1'b1;

            // When the buffer is full, accept is low, so a promotion and a
            // capture never compete. A frame captured on the boundary edge
            // itself waits for the following boundary.
            if (boundary && pending_valid_q) begin
                active_q        <= pending_q;
                pending_valid_q <= 1'b0;
            end else if (accept) begin
                pending_valid_q <= 1'b1;
            end

            an_o          <= an_next;
            sseg_o        <= sseg_next;
            dp_o          <= dp_next;
            frame_start_o <= (cnt == '0);
        end
    end

    // NOTE: the pending payload has no reset. pending_valid_q qualifies it, so
    // clearing the data would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pending_q <= '{hex: hex_i, dp: dp_i, blank: blank_i};
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_mux
//
// Self-checking bench for sseg_scan_mux with N = 6, so each digit lasts 16
// clocks and each frame lasts 64 clocks.
//
// The stimulus pushes every frame it offers into a scoreboard queue. Each
// entry records the edge on which the frame is accepted, the boundary edge
// that promotes it, and the frame number in which it first appears. The
// monitor samples on the falling edge and compares every output word against
// the frame it expects to be live at that moment.
// -----------------------------------------------------------------------------
module tb_sseg_scan_mux;

    localparam int N     = 6;
    localparam int FRAME = 1 << N;
    localparam int DIGIT = FRAME / 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] hex_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic        frame_valid_i = 1'b0;
    logic        frame_ready_o;
    logic        frame_start_o;
    logic [3:0]  an_o;
    logic [6:0]  sseg_o;
    logic        dp_o;

    always #5 clk = ~clk;

    sseg_scan_mux #(.N(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .hex_i         (hex_i),
        .dp_i          (dp_i),
        .blank_i       (blank_i),
        .frame_valid_i (frame_valid_i),
        .frame_ready_o (frame_ready_o),
        .frame_start_o (frame_start_o),
        .an_o          (an_o),
        .sseg_o        (sseg_o),
        .dp_o          (dp_o)
    );

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        int          a;       // edge on which the frame is accepted
        int          b;       // boundary edge that promotes it
        int          live_k;  // frame number in which it first shows
    } item_t;

    item_t sb[$];
    item_t act_exp;

    int n_vec    = 0;
    int n_fail   = 0;
    int edge_cnt = 0;  // index of the next rising edge since reset release

    // Active-low {g,f,e,d,c,b,a} reference table.
    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    always @(posedge clk) edge_cnt <= rst_i ? 0 : edge_cnt + 1;

    // ---------------------------------------------------------------- monitor
    int         m_e, m_c, m_k, m_d;
    logic       m_pend;
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp;

    always @(negedge clk) begin
        if (edge_cnt == 0) begin
            // The last rising edge saw reset, so expect the reset state.
            sb.delete();
            act_exp.hex   = 16'h0000;
            act_exp.dp    = 4'h0;
            act_exp.blank = 4'hF;
            check("rst_an", 32'(an_o), 32'hF);
            check("rst_sseg", 32'(sseg_o), 32'h7F);
            check("rst_dp", 32'(dp_o), 32'h1);
            check("rst_fstart", 32'(frame_start_o), 32'h0);
            check("rst_ready", 32'(frame_ready_o), 32'h1);
        end else begin
            m_e = edge_cnt - 1;  // edge whose result is visible now
            m_c = m_e % FRAME;   // pre-edge counter value of that edge
            m_k = m_e / FRAME;
            m_d = m_c / DIGIT;
            if (m_c == 0) begin
                while (sb.size() > 0 && sb[0].live_k == m_k) act_exp = sb.pop_front();
            end
            m_pend = 1'b0;
            foreach (sb[i]) if (sb[i].a <= m_e && m_e < sb[i].b) m_pend = 1'b1;

            x_an  = 4'b1111;
            x_seg = 7'b1111111;
            x_dp  = 1'b1;
            if (!act_exp.blank[m_d]) begin
                x_an[m_d] = 1'b0;
                x_seg     = seg_tab[act_exp.hex[m_d*4 +: 4]];
                x_dp      = ~act_exp.dp[m_d];
            end
            check("an", 32'(an_o), 32'(x_an));
            check("sseg", 32'(sseg_o), 32'(x_seg));
            check("dp", 32'(dp_o), 32'(x_dp));
            check("frame_start", 32'(frame_start_o), 32'(m_c == 0));
            check("ready", 32'(frame_ready_o), 32'(!m_pend));
        end
    end

    // --------------------------------------------------------------- stimulus
    // Record a frame that the DUT accepts on edge a.
    task automatic push_item(input logic [15:0] h, input logic [3:0] d,
                             input logic [3:0] bl, input int a);
        item_t it;
        int    c;
        c         = a % FRAME;
        it.hex    = h;
        it.dp     = d;
        it.blank  = bl;
        it.a      = a;
        // A capture on the wrap edge misses that boundary and waits for the next one.
        it.b      = (c == FRAME - 1) ? a + FRAME : a + (FRAME - 1 - c);
        it.live_k = (it.b + 1) / FRAME;
        sb.push_back(it);
    endtask

    // Advance to the falling edge whose following rising edge sees counter value c.
    task automatic wait_to_cnt(input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((edge_cnt % FRAME) != c && n < 4 * FRAME);
        if ((edge_cnt % FRAME) != c) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_to_cnt: got %0d, expected %0d", edge_cnt % FRAME, c);
        end
    endtask

    // Offer a frame for one clock; the caller ensures the buffer is empty.
    task automatic send(input logic [15:0] h, input logic [3:0] d, input logic [3:0] bl);
        hex_i         = h;
        dp_i          = d;
        blank_i       = bl;
        frame_valid_i = 1'b1;
        push_item(h, d, bl, edge_cnt);
        @(negedge clk);
        frame_valid_i = 1'b0;
    endtask

    initial begin
        int a1, b1, a2;

        // Reset for four clocks, then run idle.
        repeat (4) @(negedge clk);
        rst_i = 1'b0;
        repeat (130) @(negedge clk);

        // First frame: digit 2 has its decimal point lit.
        wait_to_cnt(10);
        send(16'h1234, 4'b0100, 4'b0000);

        // Backpressure: EEEE is held while the buffer is full. The DUT takes
        // it on the edge after the boundary that promotes ABCD.
        wait_to_cnt(5);
        a1 = edge_cnt;
        b1 = a1 + (FRAME - 1 - (a1 % FRAME));
        a2 = b1 + 1;
        hex_i         = 16'hABCD;
        dp_i          = 4'b1000;
        blank_i       = 4'b0000;
        frame_valid_i = 1'b1;
        push_item(16'hABCD, 4'b1000, 4'b0000, a1);
        push_item(16'hEEEE, 4'b0000, 4'b0000, a2);
        @(negedge clk);
        hex_i = 16'hEEEE;
        dp_i  = 4'b0000;
        while (edge_cnt != a2 + 1) @(negedge clk);
        frame_valid_i = 1'b0;

        // Boundary collision: present a frame on the cnt == 63 edge with
        // the buffer empty.
        wait_to_cnt(0);
        wait_to_cnt(FRAME - 1);
        send(16'h7E57, 4'b0011, 4'b0000);
        wait_to_cnt(0);

        // Decode sweep, then a frame with digits 1 and 3 blanked.
        wait_to_cnt(5);
        send(16'h0123, 4'b0001, 4'b0000);
        wait_to_cnt(5);
        send(16'h4567, 4'b0010, 4'b0000);
        wait_to_cnt(5);
        send(16'h89AB, 4'b0100, 4'b0000);
        wait_to_cnt(5);
        send(16'hCDEF, 4'b1000, 4'b0000);
        wait_to_cnt(5);
        send(16'h8888, 4'b1111, 4'b1010);

        // Reset mid-frame with a frame pending. Neither the pending frame
        // nor the active frame may appear afterwards.
        wait_to_cnt(5);
        send(16'h5A5A, 4'b0101, 4'b0000);
        wait_to_cnt(37);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (150) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
